// File: rtl/datapath_pkg.sv
// Shared datapath widths, well-known register numbers and word/address types.
package datapath_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;
endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: r0 forced to zero, in-flight write bypass.
// Zero latency; no flow control (pure combinational select).
module reg_read_port #(
  parameter int DATA_W = datapath_pkg::DATA_W,
  parameter int ADDR_W = datapath_pkg::ADDR_W
) (
  input  logic                                  rst_n,
  input  logic [ADDR_W-1:0]                     addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]      regs,
  input  logic                                  wr_en,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  output logic [DATA_W-1:0]                     data
);
  logic hit;

  // Bypass is gated by rst_n so reads stay zero for the whole reset window.
  assign hit = (wr_en == 1'b1) && (wr_addr == addr) && (rst_n == 1'b1);

  always_comb begin
    data = '0;
    if (addr != '0) begin
      data = hit ? wr_data : regs[addr];
    end
  end
endmodule

// File: rtl/register_file_2r1w.sv
// MIPS-style 32-entry register file, two combinational read ports and one write port.
// Reads are zero latency with same-cycle write bypass; writes land on the next posedge.
module register_file_2r1w
  import datapath_pkg::*;
#(
  parameter int DATA_W = datapath_pkg::DATA_W,
  parameter int ADDR_W = datapath_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int NUM_REGS = 2**ADDR_W;

  // Entry 0 has no storage; the read view ties it to zero.
  logic [DATA_W-1:0]                 regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_view;

  always_comb begin
    regs_view = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_view[i] = regs[i];
    end
  end

  // Strict == 1'b1 keeps an X on wr_en from corrupting storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if ((wr_en == 1'b1) && (wr_addr != REG_ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .rst_n   (rst_n),
    .addr    (rd_addr_a),
    .regs    (regs_view),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .data    (rd_data_a)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .rst_n   (rst_n),
    .addr    (rd_addr_b),
    .regs    (regs_view),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .data    (rd_data_b)
  );
endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: vector table plus reset/sweep sequences.
module tb_register_file_2r1w;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] ea;
    logic [31:0] eb;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    string       nm;
  } vec_t;
  localparam int NV = 11;
  vec_t vec [NV];

  register_file_2r1w dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    e.nm = nm; e.ea = ea; e.eb = eb;
    sb_q.push_back(e);
  endtask

  // Outputs are combinational: compare 1ns after the inputs settle.
  task automatic sb_check();
    exp_t e;
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      checks--;
      e = sb_q.pop_front();
      check({e.nm, "_a"}, rd_data_a, e.ea);
      check({e.nm, "_b"}, rd_data_b, e.eb);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec[0]  = '{1'b1,  5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        "wr_r5_byp"};
    vec[1]  = '{1'b0,  5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        "rd_r5"};
    vec[2]  = '{1'b1,  5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, "wr_r0_nobyp"};
    vec[3]  = '{1'b0,  5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        "rd_r0"};
    vec[4]  = '{1'b1,  5'd7,  32'h11111111, 5'd7,  5'd5,  32'h11111111, 32'hDEADBEEF, "wr_r7_a"};
    vec[5]  = '{1'b1,  5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222, 32'h22222222, "byp_both"};
    vec[6]  = '{1'b0,  5'd0,  32'h0,        5'd7,  5'd7,  32'h22222222, 32'h22222222, "rd_r7"};
    vec[7]  = '{1'b1,  5'd31, 32'h12345678, 5'd30, 5'd31, 32'h0,        32'h12345678, "wr_r31"};
    vec[8]  = '{1'b0,  5'd0,  32'h0,        5'd31, 5'd1,  32'h12345678, 32'h0,        "rd_r31"};
    vec[9]  = '{1'bx,  5'd5,  32'h0,        5'd6,  5'd31, 32'h0,        32'h12345678, "x_wr_en"};
    vec[10] = '{1'b0,  5'd0,  32'h0,        5'd5,  5'd7,  32'hDEADBEEF, 32'h22222222, "x_no_corrupt"};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = 5'd3; rd_addr_b = 5'd31;
    sb_push("reset_init", 32'h0, 32'h0);
    sb_check();

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      wr_en = vec[i].we; wr_addr = vec[i].wa; wr_data = vec[i].wd;
      rd_addr_a = vec[i].ra; rd_addr_b = vec[i].rb;
      sb_push(vec[i].nm, vec[i].ea, vec[i].eb);
      sb_check();
      tick();
    end

    // Sweep: write r1..r31 (bypass visible on port A), then read pairs.
    for (int n = 1; n < 32; n++) begin
      wr_en = 1'b1; wr_addr = 5'(n); wr_data = 32'hA5A50000 | 32'(n);
      rd_addr_a = 5'(n); rd_addr_b = 5'd0;
      sb_push("sweep_wr", 32'hA5A50000 | 32'(n), 32'h0);
      sb_check();
      tick();
    end
    wr_en = 1'b0;
    for (int n = 0; n < 32; n++) begin
      rd_addr_a = 5'(n); rd_addr_b = 5'(31 - n);
      sb_push("sweep_rd",
              (n == 0)  ? 32'h0 : (32'hA5A50000 | 32'(n)),
              (n == 31) ? 32'h0 : (32'hA5A50000 | 32'(31 - n)));
      sb_check();
    end

    // Reset asserted between edges with a write to r9 pending.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
    #2 rst_n = 1'b0;
    for (int n = 0; n < 32; n++) begin
      rd_addr_a = 5'(n); rd_addr_b = 5'(31 - n);
      sb_push("rst_mid", 32'h0, 32'h0);
      sb_check();
    end

    // Release mid-cycle; storage stays clear until the next write edge.
    @(negedge clk);
    #2 rst_n = 1'b1;
    rd_addr_a = 5'd9; rd_addr_b = 5'd8;
    sb_push("post_rst_byp", 32'hCAFEF00D, 32'h0);
    sb_check();
    tick();
    wr_en = 1'b0;
    rd_addr_a = 5'd9; rd_addr_b = 5'd5;
    sb_push("post_rst_wr", 32'hCAFEF00D, 32'h0);
    sb_check();

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
